uart_rx_fifo: RTL

Parametrised UART receiver with oversampled majority-vote bit recovery, selectable parity mode, and an integrated receive FIFO. It is the next-generation replacement for the single-word UART receiver: it buffers up to C_FIFO_DEPTH frames so slow consumers lose nothing, and it reports framing, parity and overrun errors separately. It sits between the board rx pin and any valid/ack consumer, such as a sigma-delta sample controller or command parser.

---
 rtl/uart_rx_fifo_if.sv | 24 ++
 rtl/uart_rx_fifo.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_if.sv
// Consumer-side bus of the UART receiver: FIFO head word, occupancy and
// sticky error flags towards the consumer, pop and error-clear back.
//   data   head word, meaningful only while valid=1
//   valid  FIFO non-empty
//   ack    pop request, ignored while valid=0
//   count  FIFO occupancy
//   full   count equals FIFO depth
//   error  sticky flags [2] overrun, [1] parity, [0] framing
//   clear  synchronous clear of the error flags
interface uart_rx_fifo_if #(
  parameter int DW = 8,
  parameter int CW = 5
);
  logic [DW-1:0] data;
  logic          valid;
  logic          ack;
  logic [CW-1:0] count;
  logic          full;
  logic [2:0]    error;
  logic          clear;

  modport master (output data, valid, count, full, error, input ack, clear);
  modport slave  (input data, valid, count, full, error, output ack, clear);
endinterface

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with 3-sample majority vote, optional parity
// and a first-word-fall-through receive FIFO with sticky error reporting.
//   clk   main clock, rising edge
//   rstb  asynchronous active-low reset
//   rx    asynchronous serial line, idle high
//   rxIf  consumer bus (data/valid/ack/count/full/error/clear)
//
// state  | meaning
// IDLE   | waiting for a falling edge on the synchronised line
// START  | timing the start bit, false start returns to IDLE
// DATA   | collecting data bits, LSB first
// PARITY | checking the parity bit
// STOP   | checking stop bits, disposition after the last one
module uart_rx_fifo #(
  parameter int C_CLK_FRQ         = 100000000,
  parameter int C_UART_RATE       = 1000000,
  parameter int C_UART_DATA_WIDTH = 8,
  parameter int C_UART_PARITY     = 1,
  parameter int C_UART_STOP       = 2,
  parameter int C_OVERSAMPLE      = 10,
  parameter int C_FIFO_DEPTH      = 16
) (
  input logic             clk,
  input logic             rstb,
  input logic             rx,
  uart_rx_fifo_if.master  rxIf
);

  localparam int C_TICK_DIV = C_CLK_FRQ / (C_UART_RATE * C_OVERSAMPLE);
  localparam int C_TW = (C_TICK_DIV > 2) ? $clog2(C_TICK_DIV) : 1;
  localparam int C_SW = $clog2(C_OVERSAMPLE + 1);
  localparam int C_BW = $clog2(C_UART_DATA_WIDTH);
  localparam int C_PW = $clog2(C_FIFO_DEPTH);
  localparam int C_CW = C_PW + 1;

  localparam logic [C_TW-1:0] C_TICK_LOAD = C_TW'(C_TICK_DIV - 1);
  localparam logic [C_SW-1:0] C_S_LO      = C_SW'(C_OVERSAMPLE / 2 - 1);
  localparam logic [C_SW-1:0] C_S_MID     = C_SW'(C_OVERSAMPLE / 2);
  localparam logic [C_SW-1:0] C_S_HI      = C_SW'(C_OVERSAMPLE / 2 + 1);
  localparam logic [C_SW-1:0] C_S_LAST    = C_SW'(C_OVERSAMPLE);
  localparam logic [C_BW-1:0] C_DATA_LAST = C_BW'(C_UART_DATA_WIDTH - 1);
  localparam logic [C_BW-1:0] C_STOP_LAST = C_BW'(C_UART_STOP - 1);
  localparam logic [C_CW-1:0] C_FULL_CNT  = C_CW'(C_FIFO_DEPTH);
  localparam logic            C_ODD       = (C_UART_PARITY == 2);

  if (C_TICK_DIV < 2) begin : gChkDiv
    $error("uart_rx_fifo: clk per sample tick must be at least 2");
  end
  if ((C_OVERSAMPLE < 4) || (C_OVERSAMPLE % 2 != 0)) begin : gChkOs
    $error("uart_rx_fifo: oversample must be even and at least 4");
  end
  if ((1 << C_PW) != C_FIFO_DEPTH || C_FIFO_DEPTH < 2) begin : gChkDepth
    $error("uart_rx_fifo: FIFO depth must be a power of 2, at least 2");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} stateT;

  stateT                        state;
  logic                         rxS1, rxS2, rxS3;
  logic [1:0]                   syncOk;
  logic                         armed;
  logic [C_TW-1:0]              tickCnt;
  logic [C_SW-1:0]              smpIdx;
  logic                         onTick;
  logic [1:0]                   smp;
  logic [C_BW-1:0]              bitCnt;
  logic [C_UART_DATA_WIDTH-1:0] shReg;
  logic                         parBad, frmBad;
  logic                         doneVld, doneFrm, donePar;
  logic                         rxFall, decide, maj;

  // armed blocks the reset value of the synchroniser from faking an edge
  // when the line is still low after reset release.
  assign rxFall = armed & rxS3 & ~rxS2;
  // smpIdx is the 1-based tick number within the bit; tick 1 sits on the
  // bit boundary, and onTick marks the clock following each tick.
  assign decide = onTick & (smpIdx == C_S_HI);
  assign maj    = (smp[0] & smp[1]) | (rxS2 & (smp[0] | smp[1]));

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rxS1    <= 1'b1;
      rxS2    <= 1'b1;
      rxS3    <= 1'b1;
      syncOk  <= '0;
      armed   <= 1'b0;
      state   <= IDLE;
      tickCnt <= '0;
      smpIdx  <= '0;
      onTick  <= 1'b0;
      smp     <= '0;
      bitCnt  <= '0;
      shReg   <= '0;
      parBad  <= 1'b0;
      frmBad  <= 1'b0;
      doneVld <= 1'b0;
      doneFrm <= 1'b0;
      donePar <= 1'b0;
    end else begin
      rxS1    <= rx;
      rxS2    <= rxS1;
      rxS3    <= rxS2;
      syncOk  <= {syncOk[0], 1'b1};
      armed   <= armed | (syncOk[1] & rxS2);
      doneVld <= 1'b0;

      if (state == IDLE) begin
        onTick <= 1'b0;
      end else if (tickCnt == '0) begin
        tickCnt <= C_TICK_LOAD;
        smpIdx  <= (smpIdx == C_S_LAST) ? C_SW'(1) : smpIdx + 1'b1;
        onTick  <= 1'b1;
      end else begin
        tickCnt <= tickCnt - 1'b1;
        onTick  <= 1'b0;
      end

      if (onTick && smpIdx == C_S_LO)  smp[0] <= rxS2;
      if (onTick && smpIdx == C_S_MID) smp[1] <= rxS2;

      case (state)
        IDLE: if (rxFall) begin
          state   <= START;
          tickCnt <= C_TICK_LOAD;
          smpIdx  <= C_SW'(1);
          onTick  <= 1'b1;
          bitCnt  <= '0;
          parBad  <= 1'b0;
          frmBad  <= 1'b0;
        end
        START: if (decide) state <= maj ? IDLE : DATA;
        DATA: if (decide) begin
          shReg <= {maj, shReg[C_UART_DATA_WIDTH-1:1]};
          if (bitCnt == C_DATA_LAST) begin
            bitCnt <= '0;
            state  <= (C_UART_PARITY != 0) ? PARITY : STOP;
          end else begin
            bitCnt <= bitCnt + 1'b1;
          end
        end
        PARITY: if (decide) begin
          parBad <= (^shReg) ^ maj ^ C_ODD;
          state  <= STOP;
        end
        STOP: if (decide) begin
          frmBad <= frmBad | ~maj;
          if (bitCnt == C_STOP_LAST) begin
            state   <= IDLE;
            doneVld <= 1'b1;
            doneFrm <= frmBad | ~maj;
            donePar <= parBad;
          end else begin
            bitCnt <= bitCnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [C_UART_DATA_WIDTH-1:0] mem [C_FIFO_DEPTH];
  logic [C_PW-1:0]              wrPtr, rdPtr;
  logic [C_CW-1:0]              count;
  logic [2:0]                   err, newErr;
  logic                         full, valid, pop, push, frameOk;

  assign full    = (count == C_FULL_CNT);
  assign valid   = (count != '0);
  assign pop     = valid & rxIf.ack;
  assign frameOk = doneVld & ~doneFrm & ~donePar;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign push    = frameOk & (~full | pop);
  assign newErr  = {frameOk & full & ~pop,
                    doneVld & ~doneFrm & donePar,
                    doneVld & doneFrm};

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= shReg;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      err   <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      err <= (rxIf.clear ? 3'b000 : err) | newErr;
    end
  end

  // memory is not reset, so the head word is forced to 0 while empty
  assign rxIf.data  = valid ? mem[rdPtr] : '0;
  assign rxIf.valid = valid;
  assign rxIf.count = count;
  assign rxIf.full  = full;
  assign rxIf.error = err;

endmodule
